circ_unrotate8_seq: RTL and testbench

CIRC_UNROTATE8_SEQ -- requirements
Module: circ_unrotate8_seq

---
 rtl/circ_unrotate8_seq_pkg.sv | 19 +
 rtl/rotl1_8.sv | 11 +
 rtl/circ_unrotate8_seq.sv | 98 +++++++++
 tb/tb_circ_unrotate8_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/circ_unrotate8_seq_pkg.sv
// Shared definitions for the rotate/shift family: widths, FSM state
// encoding and the single-position left-rotate step.
package circ_unrotate8_seq_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One-position left rotate: bit i moves to bit (i+1) mod DATA_W.
    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

endpackage

// File: rtl/rotl1_8.sv
// Combinational 8-bit rotate-left-by-one step used by the sequential rotator.
module rotl1_8
    import circ_unrotate8_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] y
);

    assign y = rotl1(a);

endmodule

// File: rtl/circ_unrotate8_seq.sv
// Sequential 8-bit left rotator: undoes a right rotation by s, one bit per
// cycle, with a start/ready handshake and a one-cycle done pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; o holds its last value
//   ST_SHIFT | rotating o left once per cycle, counter counts down to 1
//   ST_DONE  | o is final, done is high; a new start is accepted here
module circ_unrotate8_seq
    import circ_unrotate8_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  s,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] o
);

    state_t            state_q, state_d;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] o_q, o_d;
    logic [DATA_W-1:0] o_rot;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    rotl1_8 u_rotl1 (
        .a (o_q),
        .y (o_rot)
    );

    // ready is the only unregistered output: a pure decode of the state.
    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = busy_q;
    assign done  = done_q;
    assign o     = o_q;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    o_d   = a;
                    cnt_d = s;
                    // A zero rotate has nothing to shift; finish immediately.
                    if (s != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                o_d   = o_rot;
                cnt_d = cnt_q - 1'b1;
                // Terminal count: this is the last of the s rotate steps.
                if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State, counter, result and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_circ_unrotate8_seq.sv
// Self-checking bench for circ_unrotate8_seq: a cycle-level reference model
// compared on every falling edge, plus directed jobs with literal results.
module tb_circ_unrotate8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [2:0] s;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Reference model state (job-level view, not the DUT's encoding).
    int m_o = 0;
    int m_a = 0;
    int m_s = 0;
    int m_k = 0;
    bit m_ready = 1'b1;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;

    circ_unrotate8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .s     (s),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .o     (o)
    );

    always #5 clk = ~clk;

    function automatic int rotl_ref(input int x, input int k);
        return ((x << k) | (x >> (8 - k))) & 255;
    endfunction

    function automatic int rotr_ref(input int x, input int k);
        return ((x >> k) | (x << (8 - k))) & 255;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: o after k shifts of a job is a rotated left by k.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_o = 0; m_k = 0;
            m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else if (start && m_ready) begin
            m_a = int'(a); m_s = int'(s); m_k = 0; m_o = int'(a);
            m_busy  = (m_s != 0);
            m_done  = (m_s == 0);
            m_ready = (m_s == 0);
        end else if (m_busy) begin
            m_k++;
            m_o = rotl_ref(m_a, m_k);
            if (m_k == m_s) begin
                m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
            end
        end else begin
            m_done  = 1'b0;
            m_ready = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ready", ready, m_ready);
            chk("model_busy",  busy,  m_busy);
            chk("model_done",  done,  m_done);
            chk("model_o",     o,     m_o);
        end
    end

    // Drive a start for one accepted edge; returns cycle count at that edge.
    task automatic start_job(input logic [7:0] av, input logic [2:0] sv, output int acc);
        start = 1'b1; a = av; s = sv;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        start = 1'b0; a = ~av; s = sv + 3'd3;
    endtask

    // Wait (bounded) at falling edges for done; dc = edge count at that point.
    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=no_done required=done_within_20 (cycle %0d)", cyc);
    endtask

    initial begin
        int t, d, t2, seen;
        rst = 1'b1; start = 1'b0; a = 8'h00; s = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_o", o, 8'h00);
        chk("reset_ready", ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        @(negedge clk);

        // a=81, s=1: done one edge after acceptance, o=03.
        start_job(8'h81, 3'd1, t);
        wait_done(d);
        chk("r26_latency", d - t, 1);
        chk("r26_o", o, 8'h03);
        @(negedge clk);

        // a=A5, s=0: done right after acceptance, busy never seen.
        start_job(8'hA5, 3'd0, t);
        chk("r27_busy", busy, 1'b0);
        wait_done(d);
        chk("r27_latency", d - t, 0);
        chk("r27_o", o, 8'hA5);
        @(negedge clk);

        // a=01, s=7 with an ignored start during SHIFT.
        start_job(8'h01, 3'd7, t);
        chk("r28_busy_first", busy, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 8'hF0; s = 3'd4;
        @(negedge clk);
        start = 1'b0; a = 8'h33; s = 3'd2;
        chk("r29_ignored_busy", busy, 1'b1);
        wait_done(d);
        chk("r28_latency", d - t, 7);
        chk("r28_o", o, 8'h80);

        // Back-to-back start in the DONE cycle.
        start_job(8'h0F, 3'd4, t2);
        chk("r29_b2b_accept_cycle", t2, d + 1);
        wait_done(d);
        chk("r29_latency", d - t2, 4);
        chk("r29_o", o, 8'hF0);
        repeat (3) @(negedge clk);
        chk("idle_hold_o", o, 8'hF0);

        // Reset in the middle of an s=5 job.
        start_job(8'hC3, 3'd5, t);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r30_o", o, 8'h00);
        chk("r30_ready", ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("r30_no_done", seen, 0);

        // Exhaustive round trip: right-rotate then unrotate gives a back.
        for (int av = 0; av < 256; av++) begin
            for (int sv = 0; sv < 8; sv++) begin
                start_job(8'(rotr_ref(av, sv)), 3'(sv), t);
                wait_done(d);
                chk("roundtrip_latency", d - t, sv);
                chk("roundtrip_o", o, av);
            end
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
